// File: rtl/oam_dma.sv
// Sprite DMA engine: halts the CPU and copies one 256-byte page
// from {page,idx} into the PPU OAM data port, one get/put pair per byte.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_rw,
  input  logic [7:0]  bus_rdata,
  output logic        cpu_rdy,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_rw,
  output logic        dma_done
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        parity_q;

  logic        rdy_q, rdy_d;
  logic        act_q, act_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        rw_q, rw_d;
  logic        done_q, done_d;

  logic        trig;
  logic        last;

  assign trig = (cpu_addr == DMA_REG_ADDR) && !cpu_rw;
  assign last = (idx_q == LAST_IDX);

  // Outputs are registered from the next state so every bus
  // field lines up with the state it belongs to.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    rdy_d   = 1'b1;
    act_d   = 1'b0;
    addr_d  = '0;
    dout_d  = '0;
    rw_d    = 1'b1;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_HALT;
          page_d  = cpu_wdata;
          idx_d   = '0;
        end
      end
      S_HALT: begin
        state_d = parity_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        data_d  = bus_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = last ? S_IDLE : S_READ;
        done_d  = last;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    unique case (state_d)
      S_HALT: begin
        rdy_d = 1'b0;
      end
      S_ALIGN,
      S_READ: begin
        rdy_d  = 1'b0;
        act_d  = 1'b1;
        addr_d = {page_d, idx_d};
      end
      S_WRITE: begin
        rdy_d  = 1'b0;
        act_d  = 1'b1;
        rw_d   = 1'b0;
        addr_d = OAM_DATA_ADDR;
        dout_d = data_d;
      end
      default: begin
        rdy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      rdy_q    <= 1'b1;
      act_q    <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      rw_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      parity_q <= ~parity_q;
      rdy_q    <= rdy_d;
      act_q    <= act_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      rw_q     <= rw_d;
      done_q   <= done_d;
    end
  end

  assign cpu_rdy    = rdy_q;
  assign dma_active = act_q;
  assign dma_addr   = addr_q;
  assign dma_dout   = dout_q;
  assign dma_rw     = rw_q;
  assign dma_done   = done_q;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: random memory and trigger timing checked
// against transfer-level expectations (halt length, read/write streams).
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rw;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_rw;
  logic        dma_done;

  logic [7:0]  mem [0:65535];
  int          errs = 0;
  int          checks = 0;
  int          edges;
  bit          trig_par;

  oam_dma dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rw     (cpu_rw),
    .bus_rdata  (bus_rdata),
    .cpu_rdy    (cpu_rdy),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_rw     (dma_rw),
    .dma_done   (dma_done)
  );

  always #5 clk = ~clk;

  assign bus_rdata = mem[dma_addr];

  // Edges since reset: the parity of the current cycle is edges[0].
  always @(posedge clk or posedge reset)
    if (reset) edges <= 0;
    else       edges <= edges + 1;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic chk_rst(input string t);
    chk({t, ".rdy"},  cpu_rdy,    1);
    chk({t, ".act"},  dma_active, 0);
    chk({t, ".addr"}, dma_addr,   0);
    chk({t, ".dout"}, dma_dout,   0);
    chk({t, ".rw"},   dma_rw,     1);
    chk({t, ".done"}, dma_done,   0);
  endtask

  task automatic idle_in();
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_rw    = 1'b1;
  endtask

  task automatic drive_trig(input logic [7:0] pg);
    cpu_addr  = 16'h4014;
    cpu_wdata = pg;
    cpu_rw    = 1'b0;
    trig_par  = edges[0];
  endtask

  task automatic xfer(input string nm, input logic [7:0] pg,
                      input int par, input bit pre,
                      input int retrig, input int rstat,
                      input int chain);
    int halted, lead, nr, nw, ndone;
    int bad_r, bad_w, bad_wa, bad_ord;
    int al;
    bit rdy_done, got, aborted;
    logic [15:0] ea;
    logic [7:0]  ew;
    if (!pre) begin
      @(negedge clk);
      if (par >= 0)
        while (edges[0] != par[0]) @(negedge clk);
      drive_trig(pg);
    end
    // HALT parity is the opposite of the trigger cycle; a get-parity
    // HALT means the next cycle is a put, so one ALIGN read is inserted.
    al = int'(trig_par);
    @(negedge clk);
    idle_in();
    halted = 0; lead = -1; nr = 0; nw = 0; ndone = 0;
    bad_r = 0; bad_w = 0; bad_wa = 0; bad_ord = 0;
    rdy_done = 0; got = 0; aborted = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle_in();
      if (!cpu_rdy) halted++;
      if (dma_active && lead < 0) lead = cyc;
      if (dma_active && dma_rw) begin
        if (rstat >= 0 && nr - al == rstat) begin
          reset = 1'b1;
          #1;
          chk_rst({nm, ".mid"});
          @(negedge clk);
          chk_rst({nm, ".hold"});
          reset = 1'b0;
          repeat (3) begin
            @(negedge clk);
            chk({nm, ".post_act"}, dma_active, 0);
            chk({nm, ".post_rdy"}, cpu_rdy, 1);
          end
          aborted = 1;
          break;
        end
        ea = (nr < al) ? {pg, 8'h00} : {pg, 8'(nr - al)};
        if (dma_addr !== ea) bad_r++;
        if (nr >= al && nw != nr - al) bad_ord++;
        nr++;
      end
      if (dma_active && !dma_rw) begin
        ew = mem[{pg, 8'(nw)}];
        if (nw != nr - al - 1) bad_ord++;
        if (dma_dout !== ew) bad_w++;
        if (dma_addr !== 16'h2004) bad_wa++;
        if (retrig >= 0 && nw == retrig) begin
          cpu_addr  = 16'h4014;
          cpu_wdata = 8'h03;
          cpu_rw    = 1'b0;
        end
        nw++;
      end
      if (dma_done) begin
        ndone++;
        rdy_done = cpu_rdy;
        got = 1;
        if (chain >= 0) drive_trig(8'(chain));
        break;
      end
      @(negedge clk);
    end
    chk({nm, ".rd_seq"},  bad_r,   0);
    chk({nm, ".wr_data"}, bad_w,   0);
    chk({nm, ".wr_addr"}, bad_wa,  0);
    chk({nm, ".order"},   bad_ord, 0);
    if (!aborted) begin
      chk({nm, ".timeout"}, got, 1);
      chk({nm, ".halted"},  halted, 513 + al);
      chk({nm, ".lead"},    lead, 1);
      chk({nm, ".nreads"},  nr, 256 + al);
      chk({nm, ".nwrites"}, nw, 256);
      chk({nm, ".ndone"},   ndone, 1);
      chk({nm, ".rdy_done"}, rdy_done, 1);
      if (chain < 0) begin
        @(negedge clk);
        chk({nm, ".done_once"}, dma_done, 0);
        chk({nm, ".idle_act"},  dma_active, 0);
        chk({nm, ".idle_rdy"},  cpu_rdy, 1);
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pg;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    idle_in();
    reset = 1'b1;
    #1;
    chk_rst("por");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_rst("por_idle");

    xfer("even", 8'h02, 0, 0, -1, -1, -1);
    xfer("odd",  8'h02, 1, 0, -1, -1, -1);

    for (int i = 0; i < 256; i++) mem[{8'h07, 8'(i)}] = 8'(i) ^ 8'h5A;
    xfer("data", 8'h07, -1, 0, -1, -1, -1);

    xfer("retrig", 8'h02, -1, 0, 16, -1, -1);
    xfer("rstmid", 8'h02, -1, 0, -1, 128, -1);
    xfer("after_rst", 8'h04, -1, 0, -1, -1, -1);

    xfer("b2b_a", 8'h06, -1, 0, -1, -1, 5);
    xfer("b2b_b", 8'h05, -1, 1, -1, -1, -1);

    xfer("ppu_pg", 8'h2A, -1, 0, -1, -1, -1);

    repeat (4) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pg = 8'($urandom);
      xfer("rnd", pg, -1, 0, -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
